// File: rtl/max_pool_pkg.sv
// Shared types and sizing helpers for the max-pooling layers.
// Defaults here are also used by the forward pooling layer.
package max_pool_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STRIDE = 2;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      EMIT = 1'b1
   } state_e;

   function automatic int sel_width(input int stride);
      return (stride * stride > 1) ? $clog2(stride * stride) : 1;
   endfunction

   function automatic int cnt_width(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction

endpackage

// File: rtl/pool_grad_row_buf.sv
// One pooled row of {gradient, argmax offset} entries.
// Single write port, combinational read port, no reset needed.
module pool_grad_row_buf
   import max_pool_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DW    = 18,
   localparam int AW   = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/max_pool_grad_router.sv
// Max-pool backward router: buffers one pooled row, then streams the
// STRIDE full-resolution rows with each gradient placed at its argmax.
module max_pool_grad_router
   import max_pool_pkg::*;
#(
   parameter int WIDTH            = DEF_WIDTH,
   parameter int STRIDE           = DEF_STRIDE,
   parameter int INPUT_DIM_WIDTH  = 32,
   parameter int INPUT_DIM_HEIGHT = 32,
   parameter bit ROUTE_NEGATIVE   = 1'b1,
   localparam int SEL_W           = sel_width(STRIDE)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    grad_in_valid,
   output logic                    grad_in_ready,
   input  logic signed [WIDTH-1:0] grad_in_data,
   input  logic        [SEL_W-1:0] grad_in_sel,
   output logic                    grad_out_valid,
   input  logic                    grad_out_ready,
   output logic signed [WIDTH-1:0] grad_out_data,
   output logic                    grad_out_last
);

   localparam int OW  = INPUT_DIM_WIDTH / STRIDE;
   localparam int OH  = INPUT_DIM_HEIGHT / STRIDE;
   localparam int OCW = cnt_width(OW);
   localparam int ICW = cnt_width(INPUT_DIM_WIDTH);
   localparam int RW  = cnt_width(STRIDE);
   localparam int PW  = cnt_width(OH);
   localparam int BW  = WIDTH + SEL_W;
   localparam logic [31:0] S_U = 32'(STRIDE);

   if ((INPUT_DIM_WIDTH % STRIDE) != 0) begin : g_bad_w
      $error("INPUT_DIM_WIDTH must be divisible by STRIDE");
   end
   if ((INPUT_DIM_HEIGHT % STRIDE) != 0) begin : g_bad_h
      $error("INPUT_DIM_HEIGHT must be divisible by STRIDE");
   end

   state_e         state_q, state_d;
   logic           run_q, run_d;
   logic [OCW-1:0] ocol_q, ocol_d;
   logic [ICW-1:0] icol_q, icol_d;
   logic [RW-1:0]  roff_q, roff_d;
   logic [PW-1:0]  prow_q, prow_d;

   logic                    emit;
   logic                    in_fire;
   logic                    out_fire;
   logic                    end_col;
   logic                    end_win;
   logic [OCW-1:0]          oc;
   logic [31:0]             pos;
   logic [BW-1:0]           rd_word;
   logic signed [WIDTH-1:0] g;
   logic [SEL_W-1:0]        rd_sel;
   logic                    hit;

   pool_grad_row_buf #(
      .DEPTH (OW),
      .DW    (BW)
   ) u_row_buf (
      .clk   (clk),
      .we    (in_fire),
      .waddr (ocol_q),
      .wdata ({grad_in_data, grad_in_sel}),
      .raddr (oc),
      .rdata (rd_word)
   );

   assign emit     = (state_q == EMIT);
   assign in_fire  = grad_in_valid && grad_in_ready;
   assign out_fire = grad_out_valid && grad_out_ready;
   assign end_col  = (icol_q == ICW'(INPUT_DIM_WIDTH - 1));
   assign end_win  = end_col && (roff_q == RW'(STRIDE - 1));

   // Window position of the current output element within its pooled cell.
   assign oc     = OCW'(32'(icol_q) / S_U);
   assign pos    = 32'(roff_q) * S_U + 32'(icol_q) % S_U;
   assign rd_sel = rd_word[SEL_W-1:0];
   assign hit    = (32'(rd_sel) == pos);

   always_comb begin
      g = rd_word[BW-1:SEL_W];
      if (!ROUTE_NEGATIVE && g[WIDTH-1]) begin
         g = '0;
      end
   end

   assign grad_in_ready  = run_q && !emit;
   assign grad_out_valid = emit;
   assign grad_out_data  = (emit && hit) ? g : '0;
   assign grad_out_last  = emit && end_win && (prow_q == PW'(OH - 1));

   always_comb begin
      state_d = state_q;
      run_d   = 1'b1;
      ocol_d  = ocol_q;
      icol_d  = icol_q;
      roff_d  = roff_q;
      prow_d  = prow_q;
      unique case (state_q)
         FILL: begin
            if (in_fire) begin
               if (ocol_q == OCW'(OW - 1)) begin
                  ocol_d  = '0;
                  state_d = EMIT;
               end else begin
                  ocol_d = ocol_q + 1'b1;
               end
            end
         end
         EMIT: begin
            if (out_fire) begin
               if (end_col) begin
                  icol_d = '0;
                  if (end_win) begin
                     roff_d  = '0;
                     state_d = FILL;
                     prow_d  = (prow_q == PW'(OH - 1)) ? '0 : prow_q + 1'b1;
                  end else begin
                     roff_d = roff_q + 1'b1;
                  end
               end else begin
                  icol_d = icol_q + 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         run_q   <= 1'b0;
         ocol_q  <= '0;
         icol_q  <= '0;
         roff_q  <= '0;
         prow_q  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         ocol_q  <= ocol_d;
         icol_q  <= icol_d;
         roff_q  <= roff_d;
         prow_q  <= prow_d;
      end
   end

endmodule

// File: tb/tb_max_pool_grad_router.sv
// Bench for max_pool_grad_router: 4x4 input, STRIDE 2, checked against
// hand tables and a frame-level scatter model.
module tb_max_pool_grad_router;

   localparam int W  = 16;
   localparam int S  = 2;
   localparam int IW = 4;
   localparam int IH = 4;
   localparam int OW = IW / S;
   localparam int OH = IH / S;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                gi_valid = 1'b0;
   logic                gi_ready;
   logic signed [W-1:0] gi_data = '0;
   logic [1:0]          gi_sel = '0;
   logic                go_valid;
   logic                go_ready = 1'b1;
   logic signed [W-1:0] go_data;
   logic                go_last;
   logic                nn_in_ready;
   logic                nn_valid;
   logic signed [W-1:0] nn_data;
   logic                nn_last;

   max_pool_grad_router #(
      .WIDTH(W), .STRIDE(S), .INPUT_DIM_WIDTH(IW),
      .INPUT_DIM_HEIGHT(IH), .ROUTE_NEGATIVE(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .grad_in_valid(gi_valid), .grad_in_ready(gi_ready),
      .grad_in_data(gi_data), .grad_in_sel(gi_sel),
      .grad_out_valid(go_valid), .grad_out_ready(go_ready),
      .grad_out_data(go_data), .grad_out_last(go_last)
   );

   max_pool_grad_router #(
      .WIDTH(W), .STRIDE(S), .INPUT_DIM_WIDTH(IW),
      .INPUT_DIM_HEIGHT(IH), .ROUTE_NEGATIVE(1'b0)
   ) dut_nn (
      .clk(clk), .rst_n(rst_n),
      .grad_in_valid(gi_valid), .grad_in_ready(nn_in_ready),
      .grad_in_data(gi_data), .grad_in_sel(gi_sel),
      .grad_out_valid(nn_valid), .grad_out_ready(go_ready),
      .grad_out_data(nn_data), .grad_out_last(nn_last)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic signed [W-1:0] d;
      logic [1:0]          s;
   } in_t;

   typedef struct {
      logic signed [W-1:0] d;
      logic signed [W-1:0] dn;
      logic                last;
   } out_t;

   typedef struct {
      int g[2];
      int s[2];
      int e[8];
      int en[8];
      bit lastf;
   } vec_t;

   in_t  in_q[$];
   out_t exp_q[$];
   vec_t tbl[4];

   task automatic chk(input string name, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push_in(input int d, input int s);
      in_t b;
      b.d = W'(d);
      b.s = 2'(s);
      in_q.push_back(b);
   endtask

   task automatic push_exp(input int d, input int dn, input bit last);
      out_t o;
      o.d    = W'(d);
      o.dn   = W'(dn);
      o.last = last;
      exp_q.push_back(o);
   endtask

   task automatic push_vec(input int i, input bit lastf);
      for (int k = 0; k < 2; k++) push_in(tbl[i].g[k], tbl[i].s[k]);
      for (int k = 0; k < 8; k++)
         push_exp(tbl[i].e[k], tbl[i].en[k], lastf && (k == 7));
   endtask

   // Whole-frame scatter: each full-res pixel takes its cell's gradient
   // only if it is that cell's argmax position.
   task automatic model_frame(input in_t fr[OH*OW]);
      for (int r = 0; r < IH; r++) begin
         for (int c = 0; c < IW; c++) begin
            in_t b;
            int v;
            b = fr[(r / S) * OW + (c / S)];
            v = (int'(b.s) == (r % S) * S + (c % S)) ? int'(b.d) : 0;
            push_exp(v, (v < 0) ? 0 : v, (r == IH - 1) && (c == IW - 1));
         end
      end
   endtask

   // mode 0: always ready; 1: random valid/ready; 2: 3-cycle stall at beat 2
   task automatic run_stream(input int mode, input int stop_after,
                             input int budget, output int ngot,
                             output int nlast);
      int cyc = 0;
      int stalls = 0;
      int nacc = 0;
      bit done = 0;
      bit prev_stall = 0;
      bit lat_pending = 0;
      logic signed [W-1:0] pd = '0;
      logic pl = 1'b0;
      ngot  = 0;
      nlast = 0;
      while (!done) begin
         if (in_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
            gi_valid = 1'b1;
            gi_data  = in_q[0].d;
            gi_sel   = in_q[0].s;
         end else begin
            gi_valid = 1'b0;
         end
         case (mode)
            1: go_ready = ($urandom_range(0, 2) != 0);
            2: begin
               go_ready = !(ngot == 2 && stalls < 3);
               if (!go_ready) stalls++;
            end
            default: go_ready = 1'b1;
         endcase
         if (lat_pending) begin
            chk("latency_valid", go_valid, 1);
            lat_pending = 0;
         end
         if (prev_stall) begin
            chk("hold_valid", go_valid, 1);
            chk("hold_data", go_data, pd);
            chk("hold_last", go_last, pl);
         end
         if (go_valid) chk("in_ready_emit", gi_ready, 0);
         if (mode == 2 && !go_ready) chk("stall_data", go_data, -2);
         prev_stall = go_valid && !go_ready;
         pd = go_data;
         pl = go_last;
         if (gi_valid && gi_ready) begin
            void'(in_q.pop_front());
            nacc++;
            if (nacc % OW == 0) lat_pending = 1;
         end
         if (go_valid && go_ready) begin
            ngot++;
            if (go_last) nlast++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_beat: got data %0d, required no beat", go_data);
            end else begin
               out_t e;
               e = exp_q.pop_front();
               chk("out_data", go_data, e.d);
               chk("out_last", go_last, e.last);
               chk("nn_valid", nn_valid, 1);
               chk("nn_data", nn_data, e.dn);
               chk("nn_last", nn_last, e.last);
            end
         end
         if (stop_after > 0) begin
            if (ngot >= stop_after) done = 1;
         end else if (in_q.size() == 0 && exp_q.size() == 0) begin
            done = 1;
         end
         cyc++;
         if (!done && cyc > budget) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d beats, %0d still required",
                     ngot, exp_q.size());
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      gi_valid = 1'b0;
      go_ready = 1'b1;
   endtask

   initial begin
      int n;
      int nl;
      in_t fr[OH*OW];

      tbl[0].g = '{5, -2};         tbl[0].s = '{3, 0};
      tbl[0].e  = '{0, 0, -2, 0, 0, 5, 0, 0};
      tbl[0].en = '{0, 0, 0, 0, 0, 5, 0, 0};
      tbl[0].lastf = 0;
      tbl[1].g = '{7, 3};          tbl[1].s = '{1, 2};
      tbl[1].e  = '{0, 7, 0, 0, 0, 0, 3, 0};
      tbl[1].en = '{0, 7, 0, 0, 0, 0, 3, 0};
      tbl[1].lastf = 1;
      tbl[2].g = '{-1, -32768};    tbl[2].s = '{0, 3};
      tbl[2].e  = '{-1, 0, 0, 0, 0, 0, 0, -32768};
      tbl[2].en = '{0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2].lastf = 0;
      tbl[3].g = '{32767, -5};     tbl[3].s = '{2, 1};
      tbl[3].e  = '{0, 0, 0, -5, 32767, 0, 0, 0};
      tbl[3].en = '{0, 0, 0, 0, 32767, 0, 0, 0};
      tbl[3].lastf = 1;

      // reset held while upstream offers traffic
      repeat (2) @(posedge clk);
      #1;
      gi_valid = 1'b1;
      gi_data  = 16'sd99;
      gi_sel   = 2'd1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_out_valid", go_valid, 0);
         chk("rst_in_ready", gi_ready, 0);
      end
      chk("rst_out_data", go_data, 0);
      chk("rst_out_last", go_last, 0);
      chk("rst_nn_in_ready", nn_in_ready, 0);
      gi_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("fill_in_ready", gi_ready, 1);
      chk("fill_out_valid", go_valid, 0);

      for (int i = 0; i < 4; i++) begin
         push_vec(i, tbl[i].lastf);
         run_stream(0, 0, 200, n, nl);
         chk("vec_beats", n, 8);
      end

      push_vec(0, 0);
      run_stream(2, 0, 200, n, nl);
      chk("bp_beats", n, 8);

      // prow is 1 here; reset after beat 3 of the next row
      push_vec(0, 1);
      run_stream(0, 3, 200, n, nl);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", go_valid, 0);
      chk("mid_rst_last", go_last, 0);
      chk("mid_rst_data", go_data, 0);
      in_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("mid_rst_in_ready", gi_ready, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", gi_ready, 1);

      for (int pass = 0; pass < 2; pass++) begin
         for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < OH * OW; k++) begin
               case ($urandom_range(0, 5))
                  0: fr[k].d = 16'sh8000;
                  1: fr[k].d = 16'sh7fff;
                  default: fr[k].d = W'($urandom);
               endcase
               fr[k].s = 2'($urandom_range(0, 3));
               in_q.push_back(fr[k]);
            end
            model_frame(fr);
         end
         run_stream(pass, 0, 2000, n, nl);
         chk("frames_beats", n, 32);
         chk("frames_lasts", nl, 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
